// File: rtl/norm_arbiter.sv
// Two-requester front end that shares one combinational normalize unit, one transaction at a time.
// Define NORM_ARB_ROUNDROBIN_EN for round-robin arbitration; the default build is fixed priority (req0 wins).
module norm_arbiter (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [7:0]  req0_exp,
   input  logic [24:0] req0_frac,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [7:0]  req1_exp,
   input  logic [24:0] req1_frac,
   output logic [7:0]  nu_exp_in,
   output logic [24:0] nu_frac_in,
   input  logic [7:0]  nu_exp_out,
   input  logic [23:0] nu_frac_out,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [7:0]  out_exp,
   output logic [23:0] out_frac,
   output logic        out_id,
   output logic        busy
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]  state_q, state_d;
   logic [7:0]  op_exp_q, op_exp_d;
   logic [24:0] op_frac_q, op_frac_d;
   logic        id_q, id_d;
   logic [7:0]  res_exp_q, res_exp_d;
   logic [23:0] res_frac_q, res_frac_d;
   logic        gnt0, gnt1;
   logic        hs0, hs1;
`ifdef NORM_ARB_ROUNDROBIN_EN
   logic        last_q, last_d;
`endif

   // Grants require a valid request; contention is resolved by the selected policy.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
`ifdef NORM_ARB_ROUNDROBIN_EN
      if (req0_valid && req1_valid) begin
         gnt0 = last_q;
         gnt1 = ~last_q;
      end else begin
         gnt0 = req0_valid;
         gnt1 = req1_valid;
      end
`else
      gnt0 = req0_valid;
      gnt1 = req1_valid && !req0_valid;
`endif
   end

   assign req0_ready = (state_q == S_IDLE) && gnt0;
   assign req1_ready = (state_q == S_IDLE) && gnt1;
   assign hs0        = req0_valid && req0_ready;
   assign hs1        = req1_valid && req1_ready;

   always_comb begin
      state_d    = state_q;
      op_exp_d   = op_exp_q;
      op_frac_d  = op_frac_q;
      id_d       = id_q;
      res_exp_d  = res_exp_q;
      res_frac_d = res_frac_q;
`ifdef NORM_ARB_ROUNDROBIN_EN
      last_d     = last_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (hs0 || hs1) begin
               state_d   = S_CALC;
               op_exp_d  = hs1 ? req1_exp : req0_exp;
               op_frac_d = hs1 ? req1_frac : req0_frac;
               id_d      = hs1;
`ifdef NORM_ARB_ROUNDROBIN_EN
               last_d    = hs1;
`endif
            end
         end
         S_CALC: begin
            res_exp_d  = nu_exp_out;
            res_frac_d = nu_frac_out;
            state_d    = S_DONE;
         end
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         op_exp_q   <= 8'd0;
         op_frac_q  <= 25'd0;
         id_q       <= 1'b0;
         res_exp_q  <= 8'd0;
         res_frac_q <= 24'd0;
`ifdef NORM_ARB_ROUNDROBIN_EN
         last_q     <= 1'b1;
`endif
      end else begin
         state_q    <= state_d;
         op_exp_q   <= op_exp_d;
         op_frac_q  <= op_frac_d;
         id_q       <= id_d;
         res_exp_q  <= res_exp_d;
         res_frac_q <= res_frac_d;
`ifdef NORM_ARB_ROUNDROBIN_EN
         last_q     <= last_d;
`endif
      end
   end

   assign nu_exp_in  = op_exp_q;
   assign nu_frac_in = op_frac_q;
   assign out_valid  = (state_q == S_DONE);
   assign out_exp    = res_exp_q;
   assign out_frac   = res_frac_q;
   assign out_id     = id_q;
   assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_norm_arbiter.sv
// Bench for norm_arbiter: directed stimulus, a transaction-level reference model checked every cycle,
// and literal expectations for the documented scenarios. Honours NORM_ARB_ROUNDROBIN_EN like the DUT.
module tb_norm_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req0_valid, req0_ready, req1_valid, req1_ready;
   logic [7:0]  req0_exp, req1_exp;
   logic [24:0] req0_frac, req1_frac;
   logic [7:0]  nu_exp_in, nu_exp_out;
   logic [24:0] nu_frac_in;
   logic [23:0] nu_frac_out;
   logic        out_valid, out_ready, out_id, busy;
   logic [7:0]  out_exp;
   logic [23:0] out_frac;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   norm_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_exp(req0_exp), .req0_frac(req0_frac),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_exp(req1_exp), .req1_frac(req1_frac),
      .nu_exp_in(nu_exp_in), .nu_frac_in(nu_frac_in), .nu_exp_out(nu_exp_out), .nu_frac_out(nu_frac_out),
      .out_valid(out_valid), .out_ready(out_ready), .out_exp(out_exp), .out_frac(out_frac),
      .out_id(out_id), .busy(busy)
   );

   // Normalize unit: carry-out shifts right, otherwise shift the leading one to bit 23; underflow flushes to zero.
   function automatic logic [31:0] norm_f(input logic [7:0] e, input logic [24:0] f);
      logic [7:0]  re;
      logic [23:0] rf;
      int          sh;
      logic        found;
      sh = 0;
      found = 1'b0;
      if (f[24]) begin
         re = e + 8'd1;
         rf = f[24:1];
      end else if (f == 25'd0) begin
         re = 8'd0;
         rf = 24'd0;
      end else begin
         for (int i = 23; i >= 0; i--) begin
            if (!found && f[i]) begin
               sh = 23 - i;
               found = 1'b1;
            end
         end
         if (int'(e) > sh) begin
            re = e - 8'(sh);
            rf = f[23:0] << sh;
         end else begin
            re = 8'd0;
            rf = 24'd0;
         end
      end
      return {re, rf};
   endfunction

   assign {nu_exp_out, nu_frac_out} = norm_f(nu_exp_in, nu_frac_in);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   // Reference model: phase 0 = waiting for a request, 1 = computing, 2 = result offered.
   int          m_phase = 0;
   logic [7:0]  m_exp = 8'd0;
   logic [24:0] m_frac = 25'd0;
   logic        m_id = 1'b0;
`ifdef NORM_ARB_ROUNDROBIN_EN
   logic        m_last = 1'b1;
`endif

   always @(negedge clk) begin : model
      logic        g0, g1;
      logic [31:0] res;
      if (!rst_n) begin
         m_phase = 0;
         m_exp = 8'd0;
         m_frac = 25'd0;
         m_id = 1'b0;
`ifdef NORM_ARB_ROUNDROBIN_EN
         m_last = 1'b1;
`endif
      end
      if (req0_valid && req1_valid) begin
`ifdef NORM_ARB_ROUNDROBIN_EN
         g0 = (m_last == 1'b1);
         g1 = !g0;
`else
         g0 = 1'b1;
         g1 = 1'b0;
`endif
      end else begin
         g0 = req0_valid;
         g1 = req1_valid;
      end
      chk("m_busy", 32'(busy), 32'(m_phase != 0));
      chk("m_out_valid", 32'(out_valid), 32'(m_phase == 2));
      chk("m_req0_ready", 32'(req0_ready), 32'(m_phase == 0 && g0));
      chk("m_req1_ready", 32'(req1_ready), 32'(m_phase == 0 && g1));
      chk("m_nu_exp_in", 32'(nu_exp_in), 32'(m_exp));
      chk("m_nu_frac_in", 32'(nu_frac_in), 32'(m_frac));
      if (!rst_n) begin
         chk("m_rst_out_exp", 32'(out_exp), 0);
         chk("m_rst_out_frac", 32'(out_frac), 0);
         chk("m_rst_out_id", 32'(out_id), 0);
      end
      if (m_phase == 2) begin
         res = norm_f(m_exp, m_frac);
         chk("m_out_exp", 32'(out_exp), 32'(res[31:24]));
         chk("m_out_frac", 32'(out_frac), 32'(res[23:0]));
         chk("m_out_id", 32'(out_id), 32'(m_id));
      end
      if (rst_n) begin
         case (m_phase)
            0: if (g0 || g1) begin
               m_exp = g1 ? req1_exp : req0_exp;
               m_frac = g1 ? req1_frac : req0_frac;
               m_id = g1;
`ifdef NORM_ARB_ROUNDROBIN_EN
               m_last = g1;
`endif
               m_phase = 1;
            end
            1: m_phase = 2;
            default: if (out_ready) m_phase = 0;
         endcase
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      @(negedge clk);
      tick();
      rst_n = 1'b1;
   endtask

   // Offers one request and returns just after the accepting edge (first cycle of computation).
   task automatic send(input int which, input logic [7:0] e, input logic [24:0] f);
      bit done;
      done = 1'b0;
      if (which == 0) begin
         req0_valid = 1'b1; req0_exp = e; req0_frac = f;
      end else begin
         req1_valid = 1'b1; req1_exp = e; req1_frac = f;
      end
      for (int n = 0; n < 20 && !done; n++) begin
         @(negedge clk);
         if ((which == 0) ? req0_ready : req1_ready) done = 1'b1;
         tick();
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      if (!done) chk("handshake_timeout", 0, 1);
   endtask

   initial begin
      int  ids[$];
      bit  r1seen;
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_exp = 8'd0; req0_frac = 25'd0; req1_exp = 8'd0; req1_frac = 25'd0;
      out_ready = 1'b1;
      rst_n = 1'b0;
      repeat (2) tick();
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_out_exp", 32'(out_exp), 0);
      chk("rst_nu_frac_in", 32'(nu_frac_in), 0);
      rst_n = 1'b1;
      tick();

      // Carry-out operand; result two cycles after the handshake cycle.
      send(0, 8'h80, 25'h1000000);
      @(negedge clk);
      chk("lat_calc_valid", 32'(out_valid), 0);
      chk("lat_calc_busy", 32'(busy), 1);
      @(negedge clk);
      chk("lat_done_valid", 32'(out_valid), 1);
      chk("lat_done_busy", 32'(busy), 1);
      chk("basic_exp", 32'(out_exp), 32'h81);
      chk("basic_frac", 32'(out_frac), 32'h800000);
      chk("basic_id", 32'(out_id), 0);
      @(negedge clk);
      chk("basic_idle_busy", 32'(busy), 0);
      chk("basic_idle_valid", 32'(out_valid), 0);
      tick();

      // Zero fraction passes through as an exp-0 result.
      send(1, 8'h05, 25'h0);
      @(negedge clk);
      @(negedge clk);
      chk("zero_valid", 32'(out_valid), 1);
      chk("zero_exp", 32'(out_exp), 0);
      chk("zero_frac", 32'(out_frac), 0);
      chk("zero_id", 32'(out_id), 1);
      tick();

      // Stalled result with a one-cycle request pulse that must not be taken.
      out_ready = 1'b0;
      send(0, 8'h10, 25'h0400000);
      @(negedge clk);
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         chk("stall_valid", 32'(out_valid), 1);
         chk("stall_exp", 32'(out_exp), 32'h0F);
         chk("stall_frac", 32'(out_frac), 32'h800000);
         chk("stall_rdy", 32'({req0_ready, req1_ready}), 0);
         tick();
         if (i == 1) begin req0_valid = 1'b1; req1_valid = 1'b1; end
         if (i == 2) begin req0_valid = 1'b0; req1_valid = 1'b0; end
         @(negedge clk);
      end
      tick();
      out_ready = 1'b1;
      @(negedge clk);
      chk("release_valid", 32'(out_valid), 1);
      @(negedge clk);
      chk("release_idle", 32'(busy), 0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("no_extra_result", 32'(out_valid), 0);
      end
      tick();

      // Reset while computing drops the transaction.
      send(0, 8'h40, 25'h0000001);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_calc_valid", 32'(out_valid), 0);
      chk("rst_calc_busy", 32'(busy), 0);
      chk("rst_calc_operand", 32'(nu_exp_in), 0);
      @(negedge clk);
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_calc_no_result", 32'(out_valid), 0);
      end
      tick();
      send(0, 8'h40, 25'h0000001);
      @(negedge clk);
      @(negedge clk);
      chk("after_rst_exp", 32'(out_exp), 32'h29);
      chk("after_rst_frac", 32'(out_frac), 32'h800000);
      chk("after_rst_id", 32'(out_id), 0);
      tick();

      // Reset while a result is stalled.
      out_ready = 1'b0;
      send(1, 8'h22, 25'h0800000);
      @(negedge clk);
      @(negedge clk);
      chk("stall2_valid", 32'(out_valid), 1);
      #1 rst_n = 1'b0;
      #1;
      chk("rst_done_valid", 32'(out_valid), 0);
      chk("rst_done_busy", 32'(busy), 0);
      @(negedge clk);
      tick();
      rst_n = 1'b1;
      out_ready = 1'b1;
      tick();

      // Both requesters held valid: arbitration order.
      do_reset();
      r1seen = 1'b0;
      req0_valid = 1'b1; req0_exp = 8'h81; req0_frac = 25'h0800000;
      req1_valid = 1'b1; req1_exp = 8'h82; req1_frac = 25'h0C00000;
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         if (out_valid) ids.push_back(int'(out_id));
         if (req1_ready) r1seen = 1'b1;
         tick();
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      chk("arb_count", 32'(ids.size()), 4);
      if (ids.size() >= 4) begin
`ifdef NORM_ARB_ROUNDROBIN_EN
         chk("arb_seq", 32'({ids[0][3:0], ids[1][3:0], ids[2][3:0], ids[3][3:0]}), 32'h0101);
`else
         chk("arb_seq", 32'({ids[0][3:0], ids[1][3:0], ids[2][3:0], ids[3][3:0]}), 32'h0000);
         chk("arb_req1_ready_seen", 32'(r1seen), 0);
`endif
      end
      repeat (6) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
